// File: rtl/aes128_package.sv
// Shared GF(2^2)/GF(2^4) tower-field types and helpers for the AES S-box datapath.
// Normal-basis nibbles: bv2_t bit0 = W coefficient, bit1 = W^2 coefficient.
package aes128_package;

  typedef logic [1:0] bv2_t;

  typedef struct packed {
    bv2_t hi;
    bv2_t lo;
  } bv4_t;

  localparam bv4_t BV4_ONE = 4'hF;

  // x^2 * N with N = W^2
  function automatic bv2_t sq_scl_bv2(input bv2_t x);
    return {x[1], x[0] ^ x[1]};
  endfunction

  // x^-1 = x^2 in GF(2^2); squaring is a coefficient swap in normal basis
  function automatic bv2_t inv_bv2(input bv2_t x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/bv2_mul.sv
// GF(2^2) normal-basis multiplier; purely combinational, no handshake.
module bv2_mul
  import aes128_package::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);

  logic e;

  assign e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
  assign y = {e ^ (a[1] & b[1]), e ^ (a[0] & b[0])};

endmodule

// File: rtl/bv4_inv_core.sv
// One GF(2^4) inverter lane, split at the gamma register: gamma half from x,
// output half from the registered gamma and operand. Combinational only.
module bv4_inv_core
  import aes128_package::*;
(
  input  logic [3:0] x,
  output logic [1:0] gamma,
  input  logic [3:0] x_q,
  input  logic [1:0] gamma_q,
  output logic [3:0] y
);

  bv4_t xi;
  bv4_t xq;
  bv2_t hl_prod;
  bv2_t ginv;
  bv2_t y_hi;
  bv2_t y_lo;

  assign xi = x;
  assign xq = x_q;

  bv2_mul u_mul_gamma (.a(xi.hi), .b(xi.lo), .y(hl_prod));
  assign gamma = sq_scl_bv2(xi.hi ^ xi.lo) ^ hl_prod;

  assign ginv = inv_bv2(gamma_q);

  bv2_mul u_mul_hi (.a(ginv), .b(xq.lo), .y(y_hi));
  bv2_mul u_mul_lo (.a(ginv), .b(xq.hi), .y(y_lo));

  assign y = {y_hi, y_lo};

endmodule

// File: rtl/bv4_inv_pipe.sv
// Multi-lane GF(2^4) inverter, two register stages, latency 2, full throughput.
// Valid/ready per stage: a stalled stage holds; out_ready = !valid_1 || stage 2 can move.
module bv4_inv_pipe
  import aes128_package::*;
#(
  parameter int LANES = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_valid,
  output logic                 out_ready,
  input  logic [4*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic [4*LANES-1:0]   out_data
);

  logic                 s1_vld;
  logic [2*LANES-1:0]   s1_gamma;
  logic [4*LANES-1:0]   s1_x;
  logic                 s2_vld;
  logic [4*LANES-1:0]   s2_dat;

  logic [2*LANES-1:0]   gamma_c;
  logic [4*LANES-1:0]   y_c;
  logic                 rdy1;
  logic                 rdy2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bv4_inv_core u_core (
      .x       (in_data[4*i +: 4]),
      .gamma   (gamma_c[2*i +: 2]),
      .x_q     (s1_x[4*i +: 4]),
      .gamma_q (s1_gamma[2*i +: 2]),
      .y       (y_c[4*i +: 4])
    );
  end

  assign rdy2      = !s2_vld || in_ready;
  assign rdy1      = !s1_vld || rdy2;
  assign out_ready = rdy1;
  assign out_valid = s2_vld;
  assign out_data  = s2_dat;

  // Data registers load whenever their stage is ready; contents are ignored while valid is low.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_vld   <= 1'b0;
      s1_gamma <= '0;
      s1_x     <= '0;
      s2_vld   <= 1'b0;
      s2_dat   <= '0;
    end else begin
      if (rdy1) begin
        s1_vld   <= in_valid;
        s1_gamma <= gamma_c;
        s1_x     <= in_data;
      end
      if (rdy2) begin
        s2_vld <= s1_vld;
        s2_dat <= y_c;
      end
    end
  end

endmodule

// File: tb/tb_bv4_inv_pipe.sv
// Scoreboard bench for bv4_inv_pipe: hand-computed inverse table plus a log-table field model.
module tb_bv4_inv_pipe;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] in_data;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  bv4_inv_pipe #(.LANES(LANES)) dut (
    .in_clk    (clk),
    .in_rst_n  (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_data  (out_data)
  );

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] dexp;
  } sb_t;

  sb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  pushes = 0;
  int  pops   = 0;

  // Inverses worked out by hand in the {hi,lo} normal basis.
  logic [3:0] inv_tab [16] = '{4'h0, 4'hC, 4'h8, 4'h4, 4'h3, 4'hA, 4'h7, 4'h6,
                               4'h2, 4'hD, 4'h5, 4'hE, 4'h1, 4'h9, 4'hB, 4'hF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] exp_of(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = inv_tab[d[4*i +: 4]];
    return r;
  endfunction

  function automatic int lg2(input logic [1:0] a);
    case (a)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
    int s;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    s = (lg2(a) + lg2(b)) % 3;
    case (s)
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [3:0] gf4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] ne;
    ne = m2(2'b10, m2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {m2(a[3:2], b[3:2]) ^ ne, m2(a[1:0], b[1:0]) ^ ne};
  endfunction

  // Transfers complete at the next rising edge; inputs are stable from posedge+1 onward.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && out_ready) begin
        exp_q.push_back({in_data, exp_of(in_data)});
        pushes++;
      end
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual=%0h required=no beat at %0t", out_data, $time);
        end else begin
          sb_t e;
          logic ok;
          e = exp_q.pop_front();
          chk("data", {16'h0, out_data}, {16'h0, e.dexp});
          ok = 1'b1;
          for (int i = 0; i < 4; i++)
            if (e.din[4*i +: 4] != 4'h0 && gf4(e.din[4*i +: 4], out_data[4*i +: 4]) != 4'hF) ok = 1'b0;
          chk("field_product", {31'h0, ok}, 32'h1);
        end
        pops++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    @(negedge clk);
    while (!out_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!out_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual=out_ready 0 required=1 data=%0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int stalls;
    int p0;
    int n;
    logic [15:0] a_val;

    // Reset with a live-looking input
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_ready = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_out_ready", {31'h0, out_ready}, 32'h1);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Latency and identities
    send(16'h0F0F, w);
    chk("lat_after_accept", {31'h0, out_valid}, 32'h0);
    step();
    chk("lat_two_cycles", {31'h0, out_valid}, 32'h1);
    chk("identity", {16'h0, out_data}, 32'h0F0F);
    repeat (3) step();

    // Exhaustive back-to-back stream
    p0 = pops;
    stalls = 0;
    for (int v = 0; v < 65536; v++) begin
      send(v[15:0], w);
      stalls += w;
    end
    repeat (2) step();
    chk("stream_stalls", stalls, 0);
    chk("stream_pops", pops - p0, 65536);

    // Backpressure: A, B fill the pipe, C must wait
    in_ready = 1'b0;
    p0 = pushes;
    a_val = 16'h1234;
    send(a_val, w);
    send(16'h5678, w);
    in_valid = 1'b1;
    in_data  = 16'h9ABC;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_ready", {31'h0, out_ready}, 32'h0);
      chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_hold_data", {16'h0, out_data}, {16'h0, exp_of(a_val)});
    end
    chk("bp_accepted", pushes - p0, 2);
    in_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_all_accepted", pushes - p0, 3);
    chk("bp_drained", exp_q.size(), 0);

    // Full pipe with simultaneous push and pop
    in_ready = 1'b0;
    p0 = pushes;
    send(16'hA5C3, w);
    send(16'h3C5A, w);
    for (int i = 0; i < 10; i++) begin
      in_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = (16'h1111 * i[15:0]) ^ 16'h0F5A;
      #1;
      chk("pp_out_ready", {31'h0, out_ready}, 32'h1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("pp_pushes", pushes - p0, 12);
    chk("pp_drained", exp_q.size(), 0);

    // Mid-stream asynchronous reset with two beats in flight
    in_ready = 1'b0;
    send(16'hDEAD, w);
    send(16'hBEEF, w);
    chk("mr_full", {31'h0, out_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", {31'h0, out_valid}, 32'h0);
    chk("mr_async_data", {16'h0, out_data}, 32'h0);
    chk("mr_out_ready", {31'h0, out_ready}, 32'h1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_ready = 1'b1;
    repeat (3) step();
    chk("mr_no_stale", {31'h0, out_valid}, 32'h0);
    send(16'h7E81, w);
    step();
    chk("mr_next_valid", {31'h0, out_valid}, 32'h1);
    chk("mr_next_data", {16'h0, out_data}, {16'h0, exp_of(16'h7E81)});

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
